// File: rtl/flowcnt_pkg.sv
// flowcnt_pkg: default widths, FSM states and probability-word helper for the flow counter table
package flowcnt_pkg;
   localparam int DEF_ID_WIDTH = 12;
   localparam int DEF_COUNTER_WIDTH = 20;
   localparam int DEF_PD_WIDTH = 32;
   localparam int DEF_THRESH = 8;
   typedef enum logic {INIT, RUN} state_t;
   function automatic logic [63:0] pd_of(input int unsigned c, input int unsigned thresh, input int unsigned pd_w);
      int unsigned s;
      s = (c - thresh + 1 > pd_w - 1) ? pd_w - 1 : c - thresh + 1;
      return ({64{1'b1}} >> (64 - pd_w)) >> s;
   endfunction
endpackage

// File: rtl/flowcnt_table_counter_ram.sv
// counter_ram: simple dual-port RAM, synchronous read returning old data on a same-address write
module counter_ram #(
   parameter int AW = 12,
   parameter int DW = 20
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/flowcnt_table.sv
// flowcnt_table: per-flow counter table issuing exact/probabilistic update requests and committing write-backs
module flowcnt_table
   import flowcnt_pkg::*;
#(
   parameter int C_ID_WIDTH = DEF_ID_WIDTH,
   parameter int C_COUNTER_WIDTH = DEF_COUNTER_WIDTH,
   parameter int C_PD_WIDTH = DEF_PD_WIDTH,
   parameter int C_THRESH = DEF_THRESH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_pkt_valid,
   input  logic [C_ID_WIDTH-1:0]      in_pkt_id,
   output logic                       out_pkt_ready,
   output logic                       out_gen_counter_valid,
   output logic                       out_pd_valid,
   output logic [C_COUNTER_WIDTH-1:0] out_gen_counter_value,
   output logic [C_PD_WIDTH-1:0]      out_pd_value,
   output logic [C_ID_WIDTH-1:0]      out_id_value,
   input  logic                       in_update_valid,
   input  logic [C_COUNTER_WIDTH-1:0] in_counter_data_new,
   input  logic [C_ID_WIDTH-1:0]      in_id_data_next
);
   state_t state, state_nxt;
   logic init, hit, accept, s1_valid, exact, wr_en;
   logic [C_ID_WIDTH-1:0] init_addr, s1_id, wr_addr;
   logic [C_COUNTER_WIDTH-1:0] rd_data, wr_data, next_value;
   logic [C_PD_WIDTH-1:0] pd;
   counter_ram #(.AW(C_ID_WIDTH), .DW(C_COUNTER_WIDTH)) u_ram (
      .clk(clk), .we(wr_en), .waddr(wr_addr), .wdata(wr_data), .raddr(in_pkt_id), .rdata(rd_data)
   );
   // Any in-flight use of the same ID (read, request or write-back) blocks acceptance.
   always_comb begin
      init = state == INIT;
      state_nxt = (init && &init_addr) ? RUN : state;
      hit = (s1_valid && in_pkt_id == s1_id)
         || ((out_gen_counter_valid || out_pd_valid) && in_pkt_id == out_id_value)
         || (in_update_valid && in_pkt_id == in_id_data_next);
      out_pkt_ready = !rst && !init && !(in_pkt_valid && hit);
      accept = in_pkt_valid && out_pkt_ready;
      wr_en = init || in_update_valid;
      wr_addr = init ? init_addr : in_id_data_next;
      wr_data = init ? '0 : in_counter_data_new;
      exact = &rd_data || 32'(rd_data) < 32'(C_THRESH);
      next_value = (exact && !(&rd_data)) ? rd_data + C_COUNTER_WIDTH'(1) : rd_data;
      pd = C_PD_WIDTH'(pd_of(32'(rd_data), C_THRESH, C_PD_WIDTH));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         init_addr <= '0;
         s1_valid <= 1'b0;
         s1_id <= '0;
         out_gen_counter_valid <= 1'b0;
         out_pd_valid <= 1'b0;
         out_gen_counter_value <= '0;
         out_pd_value <= '0;
         out_id_value <= '0;
      end else begin
         state <= state_nxt;
         init_addr <= init ? init_addr + C_ID_WIDTH'(1) : '0;
         s1_valid <= accept;
         s1_id <= in_pkt_id;
         out_gen_counter_valid <= s1_valid && exact;
         out_pd_valid <= s1_valid && !exact;
         if (s1_valid) begin
            out_gen_counter_value <= next_value;
            out_pd_value <= pd;
            out_id_value <= s1_id;
         end
      end
   end
endmodule

// File: tb/tb_flowcnt_table.sv
// tb_flowcnt_table: directed scoreboard bench; the bench plays the one-cycle update generator
module tb_flowcnt_table;
   typedef struct {
      logic        g;
      logic [19:0] v;
      logic [31:0] pd;
      logic [11:0] id;
      int          cyc;
   } exp_t;

   logic clk, rst;
   logic a_pkt_valid, a_ready, a_gv, a_pv, a_uv;
   logic [11:0] a_pkt_id, a_id, a_uid;
   logic [19:0] a_val, a_un;
   logic [31:0] a_pd;
   logic b_pkt_valid, b_ready, b_gv, b_pv, b_uv;
   logic [3:0] b_pkt_id, b_id, b_uid, b_val, b_un;
   logic [31:0] b_pd;

   logic [19:0] model [4096];
   exp_t sb[$];
   int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
   logic pend_v = 1'b0;
   logic [19:0] pend_c = '0;
   logic [11:0] pend_id = '0;
   logic acc;

   flowcnt_table dut_a (
      .clk(clk), .rst(rst), .in_pkt_valid(a_pkt_valid), .in_pkt_id(a_pkt_id), .out_pkt_ready(a_ready),
      .out_gen_counter_valid(a_gv), .out_pd_valid(a_pv), .out_gen_counter_value(a_val),
      .out_pd_value(a_pd), .out_id_value(a_id), .in_update_valid(a_uv),
      .in_counter_data_new(a_un), .in_id_data_next(a_uid)
   );

   flowcnt_table #(.C_ID_WIDTH(4), .C_COUNTER_WIDTH(4), .C_PD_WIDTH(32), .C_THRESH(16)) dut_b (
      .clk(clk), .rst(rst), .in_pkt_valid(b_pkt_valid), .in_pkt_id(b_pkt_id), .out_pkt_ready(b_ready),
      .out_gen_counter_valid(b_gv), .out_pd_valid(b_pv), .out_gen_counter_value(b_val),
      .out_pd_value(b_pd), .out_id_value(b_id), .in_update_valid(b_uv),
      .in_counter_data_new(b_un), .in_id_data_next(b_uid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_req(input logic [11:0] id);
      exp_t e;
      logic [19:0] c;
      int s;
      c = model[id];
      e.id = id;
      e.cyc = cyc + 2;
      e.pd = '0;
      if (c == 20'hFFFFF) begin
         e.g = 1'b1;
         e.v = c;
      end else if (c < 20'd8) begin
         e.g = 1'b1;
         e.v = c + 20'd1;
      end else begin
         e.g = 1'b0;
         e.v = c;
         s = int'(c) - 7;
         if (s > 31) s = 31;
         e.pd = 32'hFFFF_FFFF >> s;
      end
      return e;
   endfunction

   // One clock: check requests, return last cycle's request as write-back, drive the next event.
   task automatic step(input logic v, input logic [11:0] id, output logic accepted);
      exp_t e;
      @(negedge clk);
      cyc++;
      if (a_gv || a_pv) begin
         chk("req_expected", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("req_kind", 64'({a_gv, a_pv}), e.g ? 64'd2 : 64'd1);
            chk("req_cycle", 64'(cyc), 64'(e.cyc));
            chk("req_id", 64'(a_id), 64'(e.id));
            chk("req_value", 64'(a_val), 64'(e.v));
            if (!e.g) chk("req_pd", 64'(a_pd), 64'(e.pd));
         end
      end
      a_uv = pend_v;
      a_un = pend_c;
      a_uid = pend_id;
      if (pend_v) model[pend_id] = pend_c;
      pend_v = a_gv || a_pv;
      pend_c = a_val;
      pend_id = a_id;
      a_pkt_valid = v;
      a_pkt_id = id;
      #1;
      accepted = v && a_ready;
      if (accepted) sb.push_back(expect_req(id));
   endtask

   task automatic idle(input int n);
      logic a;
      repeat (n) step(1'b0, '0, a);
   endtask

   task automatic send(input logic [11:0] id);
      logic a = 1'b0;
      for (int i = 0; i < 8 && !a; i++) step(1'b1, id, a);
      chk("send_accept", 64'(a), 64'd1);
   endtask

   task automatic preload(input logic [11:0] id, input logic [19:0] val);
      pend_v = 1'b1;
      pend_c = val;
      pend_id = id;
      idle(1);
   endtask

   task automatic wait_init();
      logic a;
      step(1'b0, '0, a);
      rst = 1'b0;
      for (int k = 1; k <= 4096; k++) begin
         step(1'b0, '0, a);
         if (k == 1 || k == 4095) chk("init_ready_low", 64'(a_ready), 64'd0);
         if (k == 4096) chk("init_ready_high", 64'(a_ready), 64'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_pkt_valid = 1'b0; a_pkt_id = '0; a_uv = 1'b0; a_un = '0; a_uid = '0;
      b_pkt_valid = 1'b0; b_pkt_id = '0; b_uv = 1'b0; b_un = '0; b_uid = '0;
      for (int i = 0; i < 4096; i++) model[i] = '0;
      idle(3);
      chk("rst_ready", 64'(a_ready), 64'd0);
      chk("rst_valids", 64'({a_gv, a_pv}), 64'd0);
      chk("rst_value", 64'(a_val), 64'd0);
      chk("rst_pd", 64'(a_pd), 64'd0);
      chk("rst_id", 64'(a_id), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
      wait_init();
      // ID 5 twice: exact 0->1, then 1->2 after the write-back
      step(1'b1, 12'd5, acc);
      chk("id5_accept", 64'(acc), 64'd1);
      idle(3);
      step(1'b1, 12'd5, acc);
      chk("id5_again", 64'(acc), 64'd1);
      idle(3);
      // Back-to-back same ID: held for three cycles
      step(1'b1, 12'd7, acc);
      chk("id7_accept", 64'(acc), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 12'd7, acc);
         chk("id7_hold", 64'(acc), 64'd0);
      end
      step(1'b1, 12'd7, acc);
      chk("id7_a4", 64'(acc), 64'd1);
      idle(3);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 12'(i), acc);
         chk("burst_accept", 64'(acc), 64'd1);
      end
      idle(3);
      // Exact up to 8, then probabilistic region
      repeat (9) send(12'd9);
      idle(3);
      preload(12'd9, 20'd40);
      send(12'd9);
      idle(3);
      preload(12'd9, 20'hFFFFF);
      send(12'd9);
      idle(3);
      // Narrow table: saturation without wrap
      b_uv = 1'b1; b_uid = 4'd3; b_un = 4'd14;
      idle(1);
      b_uv = 1'b0; b_pkt_valid = 1'b1; b_pkt_id = 4'd3;
      #1 chk("b_accept", 64'(b_ready), 64'd1);
      idle(1);
      b_pkt_valid = 1'b0;
      idle(1);
      chk("b_kind14", 64'({b_gv, b_pv}), 64'd2);
      chk("b_value14", 64'(b_val), 64'd15);
      chk("b_id14", 64'(b_id), 64'd3);
      idle(1);
      b_uv = 1'b1; b_un = b_val; b_uid = 4'd3;
      idle(1);
      b_uv = 1'b0; b_pkt_valid = 1'b1; b_pkt_id = 4'd3;
      #1 chk("b_accept_sat", 64'(b_ready), 64'd1);
      idle(1);
      b_pkt_valid = 1'b0;
      idle(1);
      chk("b_kind_sat", 64'({b_gv, b_pv}), 64'd2);
      chk("b_value_sat", 64'(b_val), 64'd15);
      idle(1);
      // Reset with S1 and S2 occupied
      step(1'b1, 12'd1, acc);
      step(1'b1, 12'd2, acc);
      idle(1);
      rst = 1'b1;
      idle(1);
      chk("rst_flush", 64'({a_gv, a_pv}), 64'd0);
      sb.delete();
      for (int i = 0; i < 4096; i++) model[i] = '0;
      wait_init();
      for (int i = 0; i < 4096; i++) begin
         step(1'b1, 12'(i), acc);
         chk("readback_accept", 64'(acc), 64'd1);
      end
      idle(4);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
